muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit implementing the RISC-V M-extension operations, parametrised in operand width. It sits in the execute stage beside the single-cycle ALU. The decoder routes MUL/DIV/REM-class instructions here, and the pipeline stalls on the valid/ready handshake until the result is returned.

## Interface
- `XLEN`, default 32: operand and result width; any even value ≥ 8.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kills any in-flight operation (branch/jump redirect).
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1`  in  XLEN  rs1 operand (multiplicand/dividend).
- `op2`  in  XLEN  rs2 operand (multiplier/divisor).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  XLEN  operation result.

## Operation
- **States.** IDLE, BUSY, DONE.
- **Reset.** State goes to IDLE. `in_ready`=1, `out_valid`=0, `result`=0, iteration counter=0.
- **Accept.** A request is accepted when `in_valid && in_ready && !flush`. On accept, `op`, `op1` and `op2` are latched.
- **Sign pre-processing.** The unit latches magnitudes and sign flags.
  - Signed operand: MULH both operands; MULHSU `op1` only; DIV/REM both operands.
  - Unsigned operand: MUL, MULHU and DIVU/REMU use raw values.
- **Multiply.** Radix-2 shift-add, one bit per BUSY cycle, into a 2·XLEN accumulator.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits after sign correction.
  - Sign correction is a two's-complement negate of the 2·XLEN product when the sign flags differ.
- **Divide.** Restoring division, one quotient bit per BUSY cycle.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- **Special cases.** Detected at accept; the unit goes straight to DONE with no BUSY cycles.
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `op1`.
  - Signed overflow (`op1` = most negative, `op2` = −1): DIV → `op1`; REM → 0.
- **Transitions.**
  - IDLE → BUSY on accept (normal case).
  - IDLE → DONE on accept (special case).
  - BUSY → DONE after XLEN iterations.
  - DONE → IDLE when `out_ready`.
- **Output.** `out_valid`=1 only in DONE. `result` is registered and stable while `out_valid && !out_ready`.
- **`in_ready`.** Equals 1 only in IDLE, so there is no overlap of operations.
- **Flush.**
  - From any state, the next state is IDLE and `out_valid` drops the next cycle.
  - A flush in DONE discards the unconsumed result.
  - A flush coinciding with `in_valid` suppresses the accept.
- **Priority.** `rst` > `flush` > handshake.

## Timing
- Request accepted in cycle T.
  - Iterative op: BUSY during T+1..T+XLEN; `out_valid` first high in T+XLEN+1.
  - Special-case op: `out_valid` high in T+1.
- Result handshake completes in cycle D when `out_valid && out_ready`. The state is IDLE and `in_ready`=1 in D+1.
- Minimum issue interval for back-to-back iterative ops with `out_ready` tied high: XLEN+2 cycles.
- `rst` asserted mid-BUSY: IDLE and reset output values in the next cycle; no result is produced.
- No combinational path from `in_valid`/`op*` to `out_valid`/`result`.
- `in_ready` depends only on state.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: all four multiply ops use a single-cycle combinational 2·XLEN product. They go IDLE → DONE, with `out_valid` in T+1. Division is unchanged.
- Not defined: multiplies are iterative, XLEN+1 cycles of latency.

## Test plan
- **MUL.** XLEN=32, MUL 7 × 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB, `out_valid` exactly 33 cycles after accept (1 cycle with `MULDIV_FAST_MUL_EN`).
- **MULH/MULHU/MULHSU.** MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Signed divide.** DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU → 2.
- **Special cases.** DIV x/0 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0. All of these in T+1.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE → `result` and `out_valid` stable, `in_ready`=0. Release → IDLE next cycle.
- **Flush and reset.** `flush` at T+10 of a DIV → `out_valid` never asserts, `in_ready`=1 at T+11. `rst` at T+5 → all outputs at reset values in T+6. `flush`+`in_valid` in the same cycle → no accept.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit (radix-2 shift-add, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle product.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_nx;

  logic              accept;
  logic              last;
  logic              signed1, signed2;
  logic              in_s1, in_s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div0, ovf;
  logic              direct;
  logic [XLEN-1:0]   direct_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  logic [2:0]        op_q;
  logic              s1_q, s2_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx;
  logic [XLEN:0]     rem_sh, rem_sub;
  logic [2*XLEN-1:0] div_nx;
  logic [2*XLEN-1:0] acc_nx;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   final_res;

  // Request decode: sign handling, magnitudes and special cases that skip BUSY
  always_comb begin
    signed1 = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed2 = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    in_s1   = signed1 && op1[XLEN-1];
    in_s2   = signed2 && op2[XLEN-1];
    mag1    = in_s1 ? -op1 : op1;
    mag2    = in_s2 ? -op2 : op2;
    div0    = op[2] && (op2 == '0);
    ovf     = ((op == OP_DIV) || (op == OP_REM)) && (op1 == INT_MIN) && (op2 == '1);
    direct  = div0 || ovf;
    direct_res = '0;
    if (div0) begin
      direct_res = op[1] ? op1 : '1;
    end else if (ovf) begin
      direct_res = op[1] ? '0 : op1;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {XLEN'(0), mag1} * {XLEN'(0), mag2};
    if (in_s1 ^ in_s2) begin
      fast_prod = -fast_prod;
    end
    if (!op[2]) begin
      direct     = 1'b1;
      direct_res = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  assign accept = in_valid && (state_q == IDLE) && !flush;
  assign last   = (state_q == BUSY) && (cnt_q == CNT_W'(XLEN - 1));

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (accept) state_nx = direct ? DONE : BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
    end
  end

  // One iteration step; acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nx  = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, b_q};
    div_nx  = rem_sub[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_nx  = op_q[2] ? div_nx : mul_nx;

    prod_fix = (s1_q ^ s2_q) ? -acc_nx : acc_nx;
    quo_fix  = (s1_q ^ s2_q) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem_fix  = s1_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];

    final_res = '0;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      OP_REM, OP_REMU:              final_res = rem_fix;
      default:                      final_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      s1_q  <= in_s1;
      s2_q  <= in_s2;
      b_q   <= op[2] ? mag2 : mag1;
      acc_q <= {XLEN'(0), op[2] ? mag1 : mag2};
      cnt_q <= '0;
      if (direct) begin
        result <= direct_res;
      end
    end else if ((state_q == BUSY) && !flush) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) begin
        result <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
// Expected multiply latency follows MULDIV_FAST_MUL_EN when it is defined.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    logic [7:0]  lat;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] op1, op2, result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  // Drive one request for a single cycle; returns at T+1
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output bit ok);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    ok = in_ready;
    op = o; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Issue, wait for out_valid and return result and latency (-1 on timeout)
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bit ok;
    issue(o, a, b, ok);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result;
    if (!out_valid || !ok) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_vectors(input string name, input vec_t v[6], input int n);
    logic [31:0] r;
    int lat;
    for (int i = 0; i < n; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r, lat);
      checks++;
      if (r !== v[i].want) begin
        errors++;
        $display("FAIL %s[%0d] result: got %h want %h", name, i, r, v[i].want);
      end
      checks++;
      if (lat != int'(v[i].lat)) begin
        errors++;
        $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[6];
    v[0] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 8'(MUL_LAT)};
    v[1] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 8'(MUL_LAT)};
    v[2] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 8'(MUL_LAT)};
    v[3] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'(MUL_LAT)};
    v[4] = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 8'(MUL_LAT)};
    v[5] = '{3'b001, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 8'(MUL_LAT)};
    test_vectors("mul", v, 6);
  endtask

  task automatic test_div();
    vec_t v[6];
    v[0] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 8'(DIV_LAT)};
    v[1] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 8'(DIV_LAT)};
    v[2] = '{3'b101, 32'd100,      32'd7, 32'd14,       8'(DIV_LAT)};
    v[3] = '{3'b111, 32'd100,      32'd7, 32'd2,        8'(DIV_LAT)};
    v[4] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 8'(DIV_LAT)};
    v[5] = '{3'b101, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 8'(DIV_LAT)};
    test_vectors("div", v, 6);
  endtask

  task automatic test_special();
    vec_t v[6];
    v[0] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd1};
    v[1] = '{3'b111, 32'h1234,     32'd0,        32'h00001234, 8'd1};
    v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1};
    v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1};
    v[4] = '{3'b101, 32'hABCD,     32'd0,        32'hFFFFFFFF, 8'd1};
    v[5] = '{3'b110, 32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 8'd1};
    test_vectors("special", v, 6);
  endtask

  task automatic test_backpressure();
    bit ok;
    int w = 0;
    out_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7, ok);
    while (!out_valid && w < 100) begin
      @(posedge clk); #1; w++;
    end
    checks++; if (out_valid !== 1'b1 || !ok) begin errors++; $display("FAIL bp_done: out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: result=%h out_valid=%b in_ready=%b want 0000000e 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    bit ok, seen;
    issue(3'b100, 32'hFFFFFFF9, 32'd2, ok);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || !ok) begin
      errors++;
      $display("FAIL flush_busy: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_no_result: out_valid seen=1 want 0"); end
  endtask

  task automatic test_flush_accept();
    bit seen;
    op = 3'b101; op1 = 32'd100; op2 = 32'd7;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_accept_no_result: out_valid seen=1 want 0"); end
  endtask

  task automatic test_rst_busy();
    bit ok, seen;
    issue(3'b101, 32'd100, 32'd7, ok);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || !ok) begin
      errors++;
      $display("FAIL rst_busy: in_ready=%b out_valid=%b result=%h want 1 0 00000000",
               in_ready, out_valid, result);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_no_result: out_valid seen=1 want 0"); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[3];
    int n_acc = 0;
    int w = 0;
    logic [31:0] first_res = '0;
    bit got_res = 1'b0;
    out_ready = 1'b1;
    op = 3'b101; op1 = 32'd100; op2 = 32'd7;
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (in_ready && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (out_valid && !got_res) begin
        first_res = result;
        got_res = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (n_acc < 3) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d want 3", n_acc);
    end else begin
      if (acc_cyc[1] - acc_cyc[0] != 34 || acc_cyc[2] - acc_cyc[1] != 34) begin
        errors++;
        $display("FAIL b2b_interval: got %0d,%0d want 34,34",
                 acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
    checks++;
    if (!got_res || first_res !== 32'd14) begin
      errors++;
      $display("FAIL b2b_result: got %h want 0000000e", first_res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_rst_busy();
    test_flush();
    test_flush_accept();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
